// File: rtl/ped_xwalk_if.sv
// ped_xwalk_if: signal bundle between the traffic-light side and the
// pedestrian crosswalk controller.
//
// Handshake semantics: there is no valid/ready pair. Every field is a level
// sampled on each rising clk edge. The master (traffic-light FSM plus push
// buttons) drives red/yellow/request levels continuously. The slave
// (ped_xwalk_ctrl) drives registered lamp, pending and countdown levels that
// are valid in every cycle after reset.
//
// Fields:
//   red_trffc_light [NUM_XWALK]        traffic red lamp per channel
//   ylw_trffc_light [NUM_XWALK]        traffic yellow lamp per channel
//   ped_req         [NUM_XWALK]        push-button level (pre-debounced)
//   walk_light      [NUM_XWALK]        walk lamp
//   stop_light      [NUM_XWALK]        don't-walk lamp
//   ped_wait        [NUM_XWALK]        request pending indicator
//   countdown       [NUM_XWALK*CNT_W]  clearance seconds, channel i at [i*CNT_W +: CNT_W]
interface ped_xwalk_if #(
  parameter int NUM_XWALK = 2,
  parameter int CNT_W     = 4
);
  logic [NUM_XWALK-1:0]       red_trffc_light;
  logic [NUM_XWALK-1:0]       ylw_trffc_light;
  logic [NUM_XWALK-1:0]       ped_req;
  logic [NUM_XWALK-1:0]       walk_light;
  logic [NUM_XWALK-1:0]       stop_light;
  logic [NUM_XWALK-1:0]       ped_wait;
  logic [NUM_XWALK*CNT_W-1:0] countdown;

  modport master (
    output red_trffc_light, ylw_trffc_light, ped_req,
    input  walk_light, stop_light, ped_wait, countdown
  );

  modport slave (
    input  red_trffc_light, ylw_trffc_light, ped_req,
    output walk_light, stop_light, ped_wait, countdown
  );
endinterface

// File: rtl/ped_xwalk_ctrl.sv
// ped_xwalk_ctrl: multi-channel pedestrian crosswalk controller.
//
// Each channel follows the red/yellow outputs of its traffic-light channel
// and runs STOP -> WALK -> FLASH -> STOP. Push-button requests are latched.
// WALK lasts WALK_SEC ticks. The flashing clearance lasts FLASH_SEC ticks and
// shows a seconds countdown. Dropping red during WALK or FLASH aborts to STOP
// at once. Each channel gets at most one WALK per red phase.
//
// Optional feature macro: AUTO_WALK_EN. When it is defined, every red phase
// gets one WALK with no button press needed. Presses are still latched into
// ped_wait.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   xw         ped_xwalk_if.slave: traffic lamps and buttons in; registered
//              walk/stop lamps, ped_wait and countdown out
//   state_dbg  per-channel FSM state, channel i at [2*i +: 2]
//              (0 = STOP, 1 = WALK, 2 = FLASH)
module ped_xwalk_ctrl #(
  parameter int NUM_XWALK = 2,
  parameter int TICK_DIV  = 100000000,
  parameter int WALK_SEC  = 7,
  parameter int FLASH_SEC = 5,
  parameter int CNT_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  ped_xwalk_if.slave             xw,
  output logic [2*NUM_XWALK-1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_WALK  = 2'd1,
    ST_FLASH = 2'd2
  } state_t;

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  // Shared free-running tick generator. It is never restarted on a state
  // entry, so the first tick of an interval may come early.
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  state_t                     st_q   [NUM_XWALK];
  state_t                     st_d   [NUM_XWALK];
  logic [CNT_W-1:0]           tmr_q  [NUM_XWALK];
  logic [CNT_W-1:0]           tmr_d  [NUM_XWALK];
  logic [NUM_XWALK-1:0]       phase_q, phase_d;
  logic [NUM_XWALK-1:0]       served_q, served_d;
  logic [NUM_XWALK-1:0]       wait_q, wait_d;
  logic [NUM_XWALK-1:0]       walk_q, walk_d;
  logic [NUM_XWALK-1:0]       stop_q, stop_d;
  logic [NUM_XWALK*CNT_W-1:0] cd_q, cd_d;
  logic [NUM_XWALK-1:0]       walk_ok;

  always_comb begin
    for (int i = 0; i < NUM_XWALK; i++) begin
      st_d[i]     = st_q[i];
      tmr_d[i]    = tmr_q[i];
      phase_d[i]  = phase_q[i];
      served_d[i] = served_q[i];
      wait_d[i]   = wait_q[i];

      // A press in the same cycle as the entry condition counts.
`ifdef AUTO_WALK_EN
      walk_ok[i] = xw.red_trffc_light[i] & ~xw.ylw_trffc_light[i] & ~served_q[i];
`else
      walk_ok[i] = xw.red_trffc_light[i] & ~xw.ylw_trffc_light[i] & ~served_q[i]
                   & (wait_q[i] | xw.ped_req[i]);
`endif

      case (st_q[i])
        ST_STOP: begin
          wait_d[i] = wait_q[i] | xw.ped_req[i];
          if (walk_ok[i]) begin
            st_d[i]     = ST_WALK;
            tmr_d[i]    = CNT_W'(WALK_SEC);
            wait_d[i]   = 1'b0;
            served_d[i] = 1'b1;
          end
        end
        ST_WALK: begin
          // Loss of red is a safety abort and wins over a tick.
          if (!xw.red_trffc_light[i]) begin
            st_d[i]  = ST_STOP;
            tmr_d[i] = '0;
          end else if (tick && tmr_q[i] != '0) begin
            if (tmr_q[i] == CNT_W'(1)) begin
              st_d[i]    = ST_FLASH;
              tmr_d[i]   = CNT_W'(FLASH_SEC);
              phase_d[i] = 1'b1;
            end else begin
              tmr_d[i] = tmr_q[i] - CNT_W'(1);
            end
          end
        end
        ST_FLASH: begin
          // This press is served in the next red phase.
          wait_d[i] = wait_q[i] | xw.ped_req[i];
          if (!xw.red_trffc_light[i]) begin
            st_d[i]    = ST_STOP;
            tmr_d[i]   = '0;
            phase_d[i] = 1'b0;
          end else if (tick && tmr_q[i] != '0) begin
            if (tmr_q[i] == CNT_W'(1)) begin
              st_d[i]    = ST_STOP;
              tmr_d[i]   = '0;
              phase_d[i] = 1'b0;
            end else begin
              tmr_d[i]   = tmr_q[i] - CNT_W'(1);
              phase_d[i] = ~phase_q[i];
            end
          end
        end
        default: begin
          st_d[i]  = ST_STOP;
          tmr_d[i] = '0;
        end
      endcase

      // The served flag lasts only for the current red phase.
      if (!xw.red_trffc_light[i]) begin
        served_d[i] = 1'b0;
      end

      // Lamps are decoded from the next state and registered, so they
      // change one cycle after the cause.
      walk_d[i] = (st_d[i] == ST_WALK);
      stop_d[i] = (st_d[i] == ST_STOP) | ((st_d[i] == ST_FLASH) & phase_d[i]);
      cd_d[i*CNT_W +: CNT_W] = (st_d[i] == ST_FLASH) ? tmr_d[i] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_XWALK; i++) begin
        st_q[i]  <= ST_STOP;
        tmr_q[i] <= '0;
      end
      phase_q  <= '0;
      served_q <= '0;
      wait_q   <= '0;
      walk_q   <= '0;
      stop_q   <= '1;
      cd_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_XWALK; i++) begin
        st_q[i]  <= st_d[i];
        tmr_q[i] <= tmr_d[i];
      end
      phase_q  <= phase_d;
      served_q <= served_d;
      wait_q   <= wait_d;
      walk_q   <= walk_d;
      stop_q   <= stop_d;
      cd_q     <= cd_d;
    end
  end

  assign xw.walk_light = walk_q;
  assign xw.stop_light = stop_q;
  assign xw.ped_wait   = wait_q;
  assign xw.countdown  = cd_q;

  always_comb begin
    state_dbg = '0;
    for (int i = 0; i < NUM_XWALK; i++) begin
      state_dbg[2*i +: 2] = st_q[i];
    end
  end

endmodule

// File: tb/tb_ped_xwalk_ctrl.sv
// Bench for ped_xwalk_ctrl.
//
// The driver applies inputs on the falling edge. It then advances a
// behavioural model by one rising edge and pushes the expected output vector.
// The monitor pops that vector 1 ns after the rising edge and compares it
// with the outputs.
module tb_ped_xwalk_ctrl;
  localparam int N     = 2;
  localparam int TDIV  = 4;
  localparam int WSEC  = 3;
  localparam int FSEC  = 2;
  localparam int CW    = 4;
  localparam int OUT_W = 3*N + N*CW;

  logic clk;
  logic rst;
  logic [2*N-1:0] state_dbg;

  ped_xwalk_if #(.NUM_XWALK(N), .CNT_W(CW)) xw ();

  ped_xwalk_ctrl #(
    .NUM_XWALK(N), .TICK_DIV(TDIV), .WALK_SEC(WSEC), .FLASH_SEC(FSEC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .xw(xw), .state_dbg(state_dbg)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [OUT_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mode 0 = don't walk, 1 = walking, 2 = clearance.
  // el counts ticks elapsed inside the current walk or clearance interval.
  int m_cnt;
  int m_mode[N];
  int m_el[N];
  bit m_wait[N];
  bit m_served[N];

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] y,
                            input logic [N-1:0] q, input logic rs);
    logic [N-1:0]    e_walk, e_stop, e_wait;
    logic [N*CW-1:0] e_cd;
    bit tk;
    bit want;
    if (rs) begin
      m_cnt = 0;
      for (int i = 0; i < N; i++) begin
        m_mode[i] = 0; m_el[i] = 0; m_wait[i] = 0; m_served[i] = 0;
      end
    end else begin
      tk = (m_cnt == TDIV - 1);
      m_cnt = (m_cnt + 1) % TDIV;
      for (int i = 0; i < N; i++) begin
        if (m_mode[i] == 0) begin
          m_wait[i] = m_wait[i] | q[i];
`ifdef AUTO_WALK_EN
          want = 1'b1;
`else
          want = m_wait[i];
`endif
          if (r[i] && !y[i] && !m_served[i] && want) begin
            m_mode[i] = 1; m_el[i] = 0; m_wait[i] = 0; m_served[i] = 1;
          end
        end else begin
          if (m_mode[i] == 2) m_wait[i] = m_wait[i] | q[i];
          if (!r[i]) begin
            m_mode[i] = 0;
          end else if (tk) begin
            m_el[i]++;
            if (m_mode[i] == 1 && m_el[i] == WSEC) begin
              m_mode[i] = 2; m_el[i] = 0;
            end else if (m_mode[i] == 2 && m_el[i] == FSEC) begin
              m_mode[i] = 0;
            end
          end
        end
        if (!r[i]) m_served[i] = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      e_walk[i] = (m_mode[i] == 1);
      e_stop[i] = (m_mode[i] == 0) || (m_mode[i] == 2 && (m_el[i] % 2) == 0);
      e_wait[i] = m_wait[i];
      e_cd[i*CW +: CW] = (m_mode[i] == 2) ? CW'(FSEC - m_el[i]) : '0;
    end
    exp_q.push_back({e_walk, e_stop, e_wait, e_cd});
  endtask

  // driver tasks
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] y,
                      input logic [N-1:0] q, input logic rs);
    @(negedge clk);
    rst = rs;
    xw.red_trffc_light = r;
    xw.ylw_trffc_light = y;
    xw.ped_req = q;
    model_step(r, y, q, rs);
  endtask

  task automatic hold(input logic [N-1:0] r, input logic [N-1:0] y,
                      input logic [N-1:0] q, input int cycles);
    for (int k = 0; k < cycles; k++) step(r, y, q, 1'b0);
  endtask

  // monitor
  initial begin
    logic [OUT_W-1:0] exp_v;
    logic [OUT_W-1:0] got_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {xw.walk_light, xw.stop_light, xw.ped_wait, xw.countdown};
        n_checks++;
        if (got_v === exp_v) begin
          n_pass++;
        end else begin
          $display("FAIL outputs t=%0t got walk=%b stop=%b wait=%b cd=%h required walk=%b stop=%b wait=%b cd=%h",
                   $time, got_v[OUT_W-1 -: N], got_v[OUT_W-N-1 -: N], got_v[OUT_W-2*N-1 -: N],
                   got_v[N*CW-1:0], exp_v[OUT_W-1 -: N], exp_v[OUT_W-N-1 -: N],
                   exp_v[OUT_W-2*N-1 -: N], exp_v[N*CW-1:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [N-1:0] r, y, q;
    int guard;
    rst = 1'b1;
    xw.red_trffc_light = '0;
    xw.ylw_trffc_light = '0;
    xw.ped_req = '0;

    step(2'b00, 2'b00, 2'b00, 1'b1);
    step(2'b00, 2'b00, 2'b00, 1'b1);

    // Request latched while red is low, then a full walk and clearance.
    step(2'b00, 2'b00, 2'b01, 1'b0);
    hold(2'b00, 2'b00, 2'b00, 2);
    hold(2'b01, 2'b00, 2'b00, 24);

    // A second press in the same red phase waits for the next red phase.
    step(2'b01, 2'b00, 2'b01, 1'b0);
    hold(2'b01, 2'b00, 2'b00, 10);
    hold(2'b00, 2'b00, 2'b00, 2);
    hold(2'b01, 2'b00, 2'b00, 24);

    // Both channels walk. Channel 0 red drops mid-walk, channel 1 continues.
    hold(2'b00, 2'b00, 2'b00, 2);
    step(2'b11, 2'b00, 2'b11, 1'b0);
    hold(2'b11, 2'b00, 2'b00, 4);
    hold(2'b10, 2'b00, 2'b00, 22);

    // Yellow overlapping red blocks entry until yellow clears.
    hold(2'b00, 2'b00, 2'b00, 2);
    step(2'b00, 2'b00, 2'b10, 1'b0);
    hold(2'b10, 2'b10, 2'b00, 6);
    hold(2'b10, 2'b00, 2'b00, 22);

    // Reset in the middle of a walk or clearance interval.
    hold(2'b00, 2'b00, 2'b00, 2);
    step(2'b01, 2'b00, 2'b01, 1'b0);
    hold(2'b01, 2'b00, 2'b00, 14);
    step(2'b01, 2'b00, 2'b00, 1'b1);
    hold(2'b01, 2'b00, 2'b00, 4);
    hold(2'b00, 2'b00, 2'b00, 2);
    hold(2'b01, 2'b00, 2'b00, 24);

    // Random traffic with slow red phases, rare yellow overlap and presses.
    r = '0; y = '0;
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 29) == 0) r[i] = ~r[i];
        y[i] = ($urandom_range(0, 15) == 0);
        q[i] = ($urandom_range(0, 7) == 0);
      end
      step(r, y, q, ($urandom_range(0, 499) == 0));
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
